// File: rtl/calc_pkg.sv
// Shared encodings for the RPN stack calculator: command opcodes, error codes
// and control FSM states.
package calc_pkg;

  typedef enum logic [2:0] {
    CMD_PUSH  = 3'd0,
    CMD_POP   = 3'd1,
    CMD_ADD   = 3'd2,
    CMD_SUB   = 3'd3,
    CMD_MULT  = 3'd4,
    CMD_DUP   = 3'd5,
    CMD_SWAP  = 3'd6,
    CMD_CLEAR = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_UNDER = 2'd1,
    ERR_OVER  = 2'd2,
    ERR_ARITH = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MULT_RUN  = 2'd1,
    ST_MULT_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult.sv
// Signed shift-add multiplier: one partial product per cycle, WIDTH cycles total.
// The start cycle folds in bit 0; the sign bit of b carries negative weight.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int IW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [IW-1:0]      idx_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] term_s;
  logic [2*WIDTH-1:0] a_ext_s;

  always_comb begin
    a_ext_s = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    if (mplier_q[idx_q]) begin
      term_s = mcand_q << idx_q;
    end else begin
      term_s = {(2*WIDTH){1'b0}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      idx_q    <= {IW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_ext_s;
      mplier_q <= b_i;
      acc_q    <= b_i[0] ? a_ext_s : {(2*WIDTH){1'b0}};
      idx_q    <= IW'(1);
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else if (busy_q) begin
      // The MSB of a two's complement multiplier weighs -2^(WIDTH-1).
      if (idx_q == IW'(WIDTH - 1)) begin
        acc_q  <= acc_q - term_s;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        acc_q  <= acc_q + term_s;
        done_q <= 1'b0;
      end
      idx_q <= idx_q + IW'(1);
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/rpn_stack_calc.sv
// RPN stack calculator: register-array stack with single-cycle ops and a
// multi-cycle signed MULT, wrap or saturate on arithmetic overflow.
module rpn_stack_calc
  import calc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic                       Clk,
  input  logic                       nReset,
  input  logic [WIDTH-1:0]           Din,
  input  logic                       CmdValid,
  input  logic [2:0]                 Cmd,
  output logic                       CmdReady,
  output logic [WIDTH-1:0]           Dout,
  output logic                       Dval,
  output logic [$clog2(DEPTH):0]     Count,
  output logic [1:0]                 Err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0]   stk_q [DEPTH];
  logic [WIDTH-1:0]   stk_d [DEPTH];
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         err_q, err_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dval_q, ready_q;
  logic [PW-1:0]      tidx_s, nidx_s, tnew_s;
  logic [WIDTH-1:0]   top_s, nxt_s;
  logic [2*WIDTH-1:0] a_ext_s, b_ext_s, prod_s;
  logic [WIDTH:0]     fit_ab_s, fit_mul_s;
  logic               accept_s, mult_start_s, mult_done_s;

  // Returns {overflow, stored value} for an exact 2*WIDTH-bit result.
  function automatic logic [WIDTH:0] fit(input logic [2*WIDTH-1:0] r);
    logic             ovf;
    logic [WIDTH-1:0] v;
    ovf = (r[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b0}}) &&
          (r[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b1}});
    if (ovf && (SATURATE != 0)) begin
      v = r[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      v = r[WIDTH-1:0];
    end
    return {ovf, v};
  endfunction

  seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk_i     (Clk),
    .rst_ni    (nReset),
    .start_i   (mult_start_s),
    .a_i       (nxt_s),
    .b_i       (top_s),
    .done_o    (mult_done_s),
    .product_o (prod_s)
  );

  always_comb begin
    accept_s  = CmdValid && ready_q;
    tidx_s    = cnt_q[PW-1:0] - PW'(1);
    nidx_s    = cnt_q[PW-1:0] - PW'(2);
    top_s     = stk_q[tidx_s];
    nxt_s     = stk_q[nidx_s];
    a_ext_s   = {{WIDTH{nxt_s[WIDTH-1]}}, nxt_s};
    b_ext_s   = {{WIDTH{top_s[WIDTH-1]}}, top_s};
    fit_ab_s  = fit((Cmd == CMD_SUB) ? (a_ext_s - b_ext_s) : (a_ext_s + b_ext_s));
    fit_mul_s = fit(prod_s);
  end

  always_comb begin
    state_d      = state_q;
    stk_d        = stk_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    mult_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (Cmd)
            CMD_PUSH: begin
              if (cnt_q == CW'(DEPTH)) begin
                err_d = ERR_OVER;
              end else begin
                stk_d[cnt_q[PW-1:0]] = Din;
                cnt_d = cnt_q + CW'(1);
                err_d = ERR_NONE;
              end
            end
            CMD_POP: begin
              if (cnt_q == CW'(0)) begin
                err_d = ERR_UNDER;
              end else begin
                cnt_d = cnt_q - CW'(1);
                err_d = ERR_NONE;
              end
            end
            CMD_ADD, CMD_SUB: begin
              if (cnt_q < CW'(2)) begin
                err_d = ERR_UNDER;
              end else begin
                stk_d[nidx_s] = fit_ab_s[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                err_d = fit_ab_s[WIDTH] ? ERR_ARITH : ERR_NONE;
              end
            end
            CMD_MULT: begin
              if (cnt_q < CW'(2)) begin
                err_d = ERR_UNDER;
              end else begin
                mult_start_s = 1'b1;
                state_d      = ST_MULT_RUN;
              end
            end
            CMD_DUP: begin
              if (cnt_q == CW'(0)) begin
                err_d = ERR_UNDER;
              end else if (cnt_q == CW'(DEPTH)) begin
                err_d = ERR_OVER;
              end else begin
                stk_d[cnt_q[PW-1:0]] = top_s;
                cnt_d = cnt_q + CW'(1);
                err_d = ERR_NONE;
              end
            end
            CMD_SWAP: begin
              if (cnt_q < CW'(2)) begin
                err_d = ERR_UNDER;
              end else begin
                stk_d[tidx_s] = nxt_s;
                stk_d[nidx_s] = top_s;
                err_d = ERR_NONE;
              end
            end
            CMD_CLEAR: begin
              cnt_d = CW'(0);
              err_d = ERR_NONE;
            end
            default: err_d = ERR_NONE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MULT_RUN: begin
        if (mult_done_s) begin
          state_d = ST_MULT_DONE;
        end else begin
          state_d = ST_MULT_RUN;
        end
      end
      ST_MULT_DONE: begin
        stk_d[nidx_s] = fit_mul_s[WIDTH-1:0];
        cnt_d   = cnt_q - CW'(1);
        err_d   = fit_mul_s[WIDTH] ? ERR_ARITH : ERR_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Dout is registered from the post-command stack so it tracks the new top.
    tnew_s = cnt_d[PW-1:0] - PW'(1);
    if (cnt_d == CW'(0)) begin
      dout_d = {WIDTH{1'b0}};
    end else begin
      dout_d = stk_d[tnew_s];
    end
  end

  always_ff @(posedge Clk) begin
    stk_q <= stk_d;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CW'(0);
      err_q   <= ERR_NONE;
      dout_q  <= {WIDTH{1'b0}};
      dval_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      dval_q  <= (cnt_d != CW'(0));
      ready_q <= (state_d == ST_IDLE);
    end
  end

  assign CmdReady = ready_q;
  assign Dout     = dout_q;
  assign Dval     = dval_q;
  assign Count    = cnt_q;
  assign Err      = err_q;

endmodule
